// File: rtl/dekatron_pkg.sv
// Shared types, constants and helpers for the dekatron counter chain.
package dekatron_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RIPPLE = 1'b1
    } state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Load digits outside the radix saturate to the top digit value.
    function automatic logic [15:0] clamp_digit(input logic [15:0] v, input int base);
        return (int'(v) >= base) ? 16'(base - 1) : v;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/dekatron_digit.sv
// One radix-BASE digit register with step, load and a combinational wrap flag.
module dekatron_digit
    import dekatron_pkg::*;
#(
    parameter int BASE = 10,
    parameter int DW   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          step_i,
    input  logic          dir_i,
    input  logic          load_i,
    input  logic [DW-1:0] load_val_i,
    output logic [DW-1:0] dig_o,
    output logic          wrap_o
);

    logic [DW-1:0] dig_q, dig_d;

    // Wrap means "this digit would carry/borrow if stepped in dir_i".
    assign wrap_o = (dir_i == DIR_DN) ? (dig_q == '0) : (dig_q == DW'(BASE - 1));
    assign dig_o  = dig_q;

    always_comb begin
        dig_d = dig_q;
        if (load_i) begin
            dig_d = load_val_i;
        end else if (step_i) begin
            if (wrap_o)
                dig_d = (dir_i == DIR_DN) ? DW'(BASE - 1) : '0;
            else
                dig_d = (dir_i == DIR_DN) ? dig_q - DW'(1) : dig_q + DW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) dig_q <= '0;
        else      dig_q <= dig_d;
    end

endmodule

// File: rtl/dekatron_counter.sv
// Multi-digit radix-BASE up/down counter; carry ripples one digit per clock or resolves at once.
module dekatron_counter
    import dekatron_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BASE   = 10,
    parameter int DW     = 4,
    parameter int RIPPLE = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ,
    input  logic                 DIR,
    input  logic                 LOAD,
    input  logic [DIGITS*DW-1:0] LOAD_VALUE,
    output logic                 READY,
    output logic [DIGITS*DW-1:0] COUNT,
    output logic                 ZERO,
    output logic                 OVF
);

    localparam int KW = (DIGITS > 1) ? clog2(DIGITS) : 1;

    if (clog2(BASE) > DW) begin : g_bad_dw
        $error("DW too narrow for BASE");
    end

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic            dir_q;
    logic            ovf_q;

    logic [DIGITS-1:0] step, wrap;
    logic              acc_req, acc_load, dir_mux, run;

    assign READY    = (state_q == ST_IDLE);
    assign acc_load = READY && LOAD;
    assign acc_req  = READY && REQ && !LOAD;
    assign dir_mux  = (state_q == ST_RIPPLE) ? dir_q : DIR;

    always_comb begin
        step = '0;
        run  = acc_req;
        for (int i = 0; i < DIGITS; i++) begin
            if (RIPPLE == 0) begin
                step[i] = run;
                run     = run && wrap[i];
            end else if (i == 0) begin
                step[i] = acc_req;
            end else begin
                step[i] = (state_q == ST_RIPPLE) && (k_q == KW'(i));
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        dekatron_digit #(.BASE(BASE), .DW(DW)) u_dig (
            .CLK        (CLK),
            .RST        (RST),
            .step_i     (step[g]),
            .dir_i      (dir_mux),
            .load_i     (acc_load),
            .load_val_i (DW'(clamp_digit(16'(LOAD_VALUE[g*DW +: DW]), BASE))),
            .dig_o      (COUNT[g*DW +: DW]),
            .wrap_o     (wrap[g])
        );
    end

    assign ZERO = (COUNT == '0);
    assign OVF  = ovf_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            k_q     <= KW'(1);
            dir_q   <= DIR_UP;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= step[DIGITS-1] && wrap[DIGITS-1];
            if (RIPPLE != 0) begin
                case (state_q)
                    ST_IDLE: begin
                        if (acc_req && wrap[0] && DIGITS > 1) begin
                            state_q <= ST_RIPPLE;
                            k_q     <= KW'(1);
                            dir_q   <= DIR;
                        end
                    end
                    ST_RIPPLE: begin
                        // Keep rippling only while the stepped digit wraps and more digits remain.
                        if (|(step & wrap) && k_q != KW'(DIGITS - 1))
                            k_q <= k_q + KW'(1);
                        else
                            state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dekatron_counter.sv
// Directed bench for dekatron_counter: tube-accurate ripple instance plus a fast-mode instance.
module tb_dekatron_counter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;

    logic        req_r = 0, dir_r = 0, load_r = 0;
    logic [11:0] lv_r = '0;
    logic        rdy_r, zero_r, ovf_r;
    logic [11:0] cnt_r;

    logic        req_f = 0, dir_f = 0, load_f = 0;
    logic [11:0] lv_f = '0;
    logic        rdy_f, zero_f, ovf_f;
    logic [11:0] cnt_f;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dekatron_counter #(.DIGITS(3), .BASE(10), .DW(4), .RIPPLE(1)) u_rip (
        .CLK(CLK), .RST(RST), .REQ(req_r), .DIR(dir_r), .LOAD(load_r),
        .LOAD_VALUE(lv_r), .READY(rdy_r), .COUNT(cnt_r), .ZERO(zero_r), .OVF(ovf_r)
    );

    dekatron_counter #(.DIGITS(3), .BASE(10), .DW(4), .RIPPLE(0)) u_fast (
        .CLK(CLK), .RST(RST), .REQ(req_f), .DIR(dir_f), .LOAD(load_f),
        .LOAD_VALUE(lv_f), .READY(rdy_f), .COUNT(cnt_f), .ZERO(zero_f), .OVF(ovf_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    // Checks COUNT/READY/OVF of the ripple instance in one call.
    task automatic chk_r(input string tag, input logic [11:0] c, input logic rdy, input logic ovf);
        chk({tag, ".cnt"}, 32'(cnt_r), 32'(c));
        chk({tag, ".rdy"}, 32'(rdy_r), 32'(rdy));
        chk({tag, ".ovf"}, 32'(ovf_r), 32'(ovf));
    endtask

    task automatic chk_f(input string tag, input logic [11:0] c, input logic rdy, input logic ovf);
        chk({tag, ".cnt"}, 32'(cnt_f), 32'(c));
        chk({tag, ".rdy"}, 32'(rdy_f), 32'(rdy));
        chk({tag, ".ovf"}, 32'(ovf_f), 32'(ovf));
    endtask

    task automatic ld_r(input logic [11:0] v);
        load_r = 1; lv_r = v;
        cyc();
        load_r = 0;
    endtask

    task automatic ld_f(input logic [11:0] v);
        load_f = 1; lv_f = v;
        cyc();
        load_f = 0;
    endtask

    initial begin
        cyc(); cyc();
        chk_r("reset_r", 12'h000, 1, 0);
        chk("reset_zero", 32'(zero_r), 1);
        chk_f("reset_f", 12'h000, 1, 0);
        RST = 1;

        // Ripple carry 099 -> 090 -> 000 -> 100
        ld_r(12'h099);
        chk_r("ld099", 12'h099, 1, 0);
        req_r = 1; dir_r = 0;
        cyc(); req_r = 0;
        chk_r("rip1", 12'h090, 0, 0);
        cyc();
        chk_r("rip2", 12'h000, 0, 0);
        chk("rip2_zero", 32'(zero_r), 1);
        cyc();
        chk_r("rip3", 12'h100, 1, 0);

        // Full wrap up
        ld_r(12'h999);
        req_r = 1;
        cyc(); req_r = 0;
        chk_r("wrap1", 12'h990, 0, 0);
        cyc();
        chk_r("wrap2", 12'h900, 0, 0);
        cyc();
        chk_r("wrap3", 12'h000, 1, 1);
        chk("wrap_zero", 32'(zero_r), 1);
        cyc();
        chk_r("wrap_ovf_end", 12'h000, 1, 0);

        // Borrow/wrap down from 000
        req_r = 1; dir_r = 1;
        cyc(); req_r = 0;
        chk_r("dn1", 12'h009, 0, 0);
        cyc();
        chk_r("dn2", 12'h099, 0, 0);
        cyc();
        chk_r("dn3", 12'h999, 1, 1);
        req_r = 1;
        cyc(); req_r = 0;
        chk_r("dn4", 12'h998, 1, 0);

        // Back-to-back steps with REQ held, then LOAD/REQ collision
        dir_r = 0;
        ld_r(12'h005);
        req_r = 1;
        cyc(); chk_r("b2b1", 12'h006, 1, 0);
        cyc(); chk_r("b2b2", 12'h007, 1, 0);
        cyc(); chk_r("b2b3", 12'h008, 1, 0);
        load_r = 1; lv_r = 12'h3F7;
        cyc();
        load_r = 0; req_r = 0;
        chk_r("collide_clamp", 12'h397, 1, 0);

        // LOAD and DIR change during ripple are ignored
        ld_r(12'h399);
        req_r = 1;
        cyc(); req_r = 0;
        chk_r("busy1", 12'h390, 0, 0);
        load_r = 1; lv_r = 12'h555; dir_r = 1;
        cyc(); load_r = 0;
        chk_r("busy2", 12'h300, 0, 0);
        cyc();
        chk_r("busy3", 12'h400, 1, 0);
        dir_r = 0;

        // Reset mid-ripple
        ld_r(12'h099);
        req_r = 1;
        cyc(); req_r = 0;
        chk_r("rstmid1", 12'h090, 0, 0);
        RST = 0;
        cyc(); RST = 1;
        chk_r("rstmid2", 12'h000, 1, 0);
        chk("rstmid_zero", 32'(zero_r), 1);
        cyc();
        chk_r("rstmid3", 12'h000, 1, 0);

        // Fast mode
        ld_f(12'h099);
        req_f = 1; dir_f = 0;
        cyc(); req_f = 0;
        chk_f("fast1", 12'h100, 1, 0);
        ld_f(12'h999);
        req_f = 1;
        cyc(); req_f = 0;
        chk_f("fast_wrap", 12'h000, 1, 1);
        chk("fast_zero", 32'(zero_f), 1);
        cyc();
        chk_f("fast_ovf_end", 12'h000, 1, 0);
        req_f = 1; dir_f = 1;
        cyc(); req_f = 0;
        chk_f("fast_dn", 12'h999, 1, 1);
        cyc();
        chk_f("fast_idle", 12'h999, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
